// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one radix-2 step per cycle
// on operand magnitudes, followed by a sign-fix cycle and a held result.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ALUOp,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             start_valid,
    output logic             start_ready,
    output logic             muldiv_sel,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    input  logic             flush,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, holds with stable data until that edge.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2:0]         op;
    logic               a_neg, b_neg, special;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;

    logic               accept, is_div, a_sgn, b_sgn, a_n, b_n, div0, ovf;
    logic [WIDTH-1:0]   abs_a, abs_b, spec_val, fix_val, quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign muldiv_sel  = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
    assign start_ready = (state == IDLE);
    assign accept      = start_valid && start_ready && muldiv_sel && !flush;
    assign dbg_state   = state;

    assign is_div = Funct3[2];
    assign a_sgn  = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    assign b_sgn  = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    assign a_n    = a_sgn && operand_a[WIDTH-1];
    assign b_n    = b_sgn && operand_b[WIDTH-1];
    assign abs_a  = a_n ? (~operand_a + 1'b1) : operand_a;
    assign abs_b  = b_n ? (~operand_b + 1'b1) : operand_b;
    assign div0   = is_div && (operand_b == '0);
    assign ovf    = is_div && !Funct3[0] && (operand_a == MIN_VAL) && (operand_b == '1);
    // Special results bypass CALC; they ride in the low product half into FIX.
    assign spec_val = div0 ? (Funct3[1] ? operand_a : '1) : (Funct3[1] ? '0 : MIN_VAL);

    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign div_shift = {rem, prod[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    assign prod_fix = (a_neg ^ b_neg) ? (~prod + 1'b1) : prod;
    assign quo_fix  = (a_neg ^ b_neg) ? (~prod[WIDTH-1:0] + 1'b1) : prod[WIDTH-1:0];
    assign rem_fix  = a_neg ? (~rem + 1'b1) : rem;

    always_comb begin
        fix_val = prod_fix[2*WIDTH-1:WIDTH];
        if (special)
            fix_val = prod[WIDTH-1:0];
        else if (op[2])
            fix_val = op[1] ? rem_fix : quo_fix;
        else if (op[1:0] == 2'b00)
            fix_val = prod_fix[WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (div0 || ovf) ? FIX : CALC;
            CALC: if (cnt == CW'(WIDTH)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            op           <= '0;
            a_neg        <= 1'b0;
            b_neg        <= 1'b0;
            special      <= 1'b0;
            opnd         <= '0;
            prod         <= '0;
            rem          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            if (accept) begin
                op      <= Funct3;
                a_neg   <= a_n;
                b_neg   <= b_n;
                special <= div0 || ovf;
                cnt     <= '0;
                rem     <= '0;
                if (is_div) begin
                    opnd <= abs_b;
                    prod <= {{WIDTH{1'b0}}, (div0 || ovf) ? spec_val : abs_a};
                end else begin
                    opnd <= abs_a;
                    prod <= {{WIDTH{1'b0}}, abs_b};
                end
            end else if (state == CALC && cnt != CW'(WIDTH)) begin
                cnt <= cnt + 1'b1;
                if (op[2]) begin
                    // Restoring step: quotient bits shift in at the bottom of prod.
                    rem                <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    prod[WIDTH-1:0]    <= {prod[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    prod <= prod[0] ? {mul_sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
                end
            end
            if (state == FIX) begin
                result       <= fix_val;
                result_valid <= 1'b1;
            end
            if (state == DONE && result_ready) result_valid <= 1'b0;
            if (flush) result_valid <= 1'b0;
        end
    end

endmodule
